// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its picker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Arbiter FSM: S_IDLE picks a new winner every cycle, S_BURST keeps the locked owner.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } t_arb_state;

  // Width of a requester index. It is never below one bit, so a port is never zero-width.
  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the beat counter. It can hold every value from 0 to burst inclusive.
  function automatic int f_cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: returns the first set request at or after ptr_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides what to do with the pick.
// Ports:
//   req_i   : request vector, one bit per requester
//   ptr_i   : highest-priority index for this search
//   idx_o   : index of the winning request (ptr_i when nothing is found)
//   found_o : at least one request bit is set
module rr_priority_picker #(
  parameter int G_N  = 4,
  parameter int G_IW = 2
) (
  input  logic [G_N-1:0]  req_i,
  input  logic [G_IW-1:0] ptr_i,
  output logic [G_IW-1:0] idx_o,
  output logic            found_o
);

  int              cand;
  logic [G_IW-1:0] cand_idx;

  // Walk offsets from furthest to nearest, so the nearest hit to ptr_i is written last and wins.
  always_comb begin
    idx_o    = ptr_i;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = G_N - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= G_N) begin
        cand = cand - G_N;
      end
      cand_idx = G_IW'(cand);
      if (req_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among G_NUM_REQ valid/ready requesters in bursts.
// Latency: zero-cycle combinational grant and data path; ownership state updates on the clock.
// Backpressure: i_fifo_full deasserts every ready and the write; a stall never uses up burst beats.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_valid, i_data  : per-requester valid and packed data (requester k at [k*G_WIDTH +: G_WIDTH])
//   o_ready          : per-requester accept (one-hot or zero)
//   i_fifo_full      : FIFO full flag
//   o_fifo_wr        : FIFO write enable
//   o_fifo_data      : FIFO write data
//   o_owner          : selected requester index
//   o_busy           : a burst is locked to o_owner
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int G_WIDTH   = 8,
  parameter int G_NUM_REQ = 4,
  parameter int G_BURST   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [G_NUM_REQ-1:0]           i_valid,
  input  logic [G_NUM_REQ*G_WIDTH-1:0]   i_data,
  output logic [G_NUM_REQ-1:0]           o_ready,
  input  logic                           i_fifo_full,
  output logic                           o_fifo_wr,
  output logic [G_WIDTH-1:0]             o_fifo_data,
  output logic [$clog2(G_NUM_REQ)-1:0]   o_owner,
  output logic                           o_busy
);

  localparam int               IDX_W     = f_idx_w(G_NUM_REQ);
  localparam int               CNT_W     = f_cnt_w(G_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(G_NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(G_BURST);

  t_arb_state       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] sel;
  logic             sel_vld;
  logic             xfer;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_priority_picker #(
    .G_N  (G_NUM_REQ),
    .G_IW (IDX_W)
  ) u_picker (
    .req_i   (i_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // While idle, the selection is re-evaluated every cycle. When nobody is valid, the last owner stays shown.
  always_comb begin
    sel     = owner_q;
    sel_vld = 1'b0;
    if (state_q == S_BURST) begin
      sel_vld = i_valid[owner_q];
    end else if (pick_found) begin
      sel     = pick_idx;
      sel_vld = 1'b1;
    end
  end

  // Reset gates the handshake directly, because the registers are still stale during the reset cycle.
  assign xfer = i_rst_n & sel_vld & ~i_fifo_full;

  always_comb begin
    o_ready = '0;
    if (xfer) begin
      o_ready[sel] = 1'b1;
    end
  end

  assign o_fifo_wr   = xfer;
  assign o_fifo_data = i_data[int'(sel)*G_WIDTH +: G_WIDTH];
  assign o_owner     = sel;
  assign o_busy      = (state_q == S_BURST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          // Tracking the pick keeps o_owner stable once the requests go quiet.
          owner_d = pick_idx;
          if (xfer) begin
            if (G_BURST == 1) begin
              ptr_d = f_next(pick_idx);
            end else begin
              state_d = S_BURST;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      S_BURST: begin
        if (!i_valid[owner_q]) begin
          // The owner walked away. Release without a transfer, which costs a one-cycle bubble.
          state_d = S_IDLE;
          ptr_d   = f_next(owner_q);
          cnt_d   = '0;
        end else if (xfer) begin
          if (cnt_inc == BURST_MAX) begin
            state_d = S_IDLE;
            ptr_d   = f_next(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // Valid but full: hold everything. Only an accepted beat counts.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_write_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_fifo_wr |-> !i_fifo_full);

  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_ready));

  a_cnt_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == S_BURST) |-> (cnt_q <= BURST_MAX - CNT_W'(1)));

  // A stalled owner must present the same word again, unless it withdraws valid.
  a_owner_data_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == S_BURST && i_valid[owner_q] && !xfer) |=>
      (!i_valid[owner_q] || $stable(o_fifo_data)));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic           full;

  logic [N-1:0]   rdy0, rdy1;
  logic           wr0, wr1;
  logic [W-1:0]   fd0, fd1;
  logic [1:0]     own0, own1;
  logic           busy0, busy1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N), .G_BURST(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(rdy0),
    .i_fifo_full(full), .o_fifo_wr(wr0), .o_fifo_data(fd0), .o_owner(own0), .o_busy(busy0));

  fifo_wr_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N), .G_BURST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(rdy1),
    .i_fifo_full(full), .o_fifo_wr(wr1), .o_fifo_data(fd1), .o_owner(own1), .o_busy(busy1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: who holds the port (-1 = nobody), beats taken, next priority, last shown owner.
  int m_hold[2], m_taken[2], m_ptr[2], m_last[2];
  int m_burst[2] = '{4, 1};
  logic [N-1:0] e_rdy[2];
  logic         e_wr[2];
  int           e_own[2];
  logic         e_busy[2];

  function automatic void model_eval(input int d);
    bit go;
    int cand;
    go       = 1'b0;
    e_own[d] = m_last[d];
    e_busy[d] = (m_hold[d] >= 0);
    if (m_hold[d] >= 0) begin
      e_own[d] = m_hold[d];
      go       = valid[m_hold[d]];
    end else begin
      for (int off = 0; off < N; off++) begin
        cand = (m_ptr[d] + off) % N;
        if (!go && valid[cand]) begin
          e_own[d] = cand;
          go       = 1'b1;
        end
      end
    end
    e_wr[d]  = go && !full && rst_n;
    e_rdy[d] = e_wr[d] ? (N'(1) << e_own[d]) : '0;
  endfunction

  function automatic void model_update(input int d);
    if (!rst_n) begin
      m_hold[d] = -1; m_taken[d] = 0; m_ptr[d] = 0; m_last[d] = 0;
    end else if (m_hold[d] >= 0) begin
      if (!valid[m_hold[d]]) begin
        m_ptr[d] = (m_hold[d] + 1) % N;
        m_hold[d] = -1;
      end else if (e_wr[d]) begin
        m_taken[d]++;
        if (m_taken[d] == m_burst[d]) begin
          m_ptr[d] = (m_hold[d] + 1) % N;
          m_hold[d] = -1;
        end
      end
    end else begin
      m_last[d] = e_own[d];
      if (e_wr[d]) begin
        if (m_burst[d] == 1) m_ptr[d] = (e_own[d] + 1) % N;
        else begin
          m_hold[d] = e_own[d];
          m_taken[d] = 1;
        end
      end
    end
  endfunction

  // Outputs captured at the falling edge, for the directed checks.
  logic [N-1:0] s_rdy0, s_rdy1;
  logic         s_wr0, s_wr1, s_busy0, s_busy1;
  int           s_own0, s_own1;

  // Compare against the model at the falling edge, advance the model, then return at posedge+1.
  task automatic step();
    logic [N-1:0] a_rdy;
    logic         a_wr, a_busy;
    logic [1:0]   a_own;
    logic [W-1:0] a_fd, ed;
    @(negedge clk);
    s_rdy0 = rdy0; s_rdy1 = rdy1; s_wr0 = wr0; s_wr1 = wr1;
    s_busy0 = busy0; s_busy1 = busy1; s_own0 = int'(own0); s_own1 = int'(own1);
    for (int d = 0; d < 2; d++) begin
      model_eval(d);
      a_rdy  = d ? rdy1 : rdy0;
      a_wr   = d ? wr1 : wr0;
      a_busy = d ? busy1 : busy0;
      a_own  = d ? own1 : own0;
      a_fd   = d ? fd1 : fd0;
      check($sformatf("m%0d.ready", d), 32'(a_rdy), 32'(e_rdy[d]));
      check($sformatf("m%0d.wr", d), 32'(a_wr), 32'(e_wr[d]));
      if (rst_n) begin
        ed = data[e_own[d]*W +: W];
        check($sformatf("m%0d.owner", d), 32'(a_own), 32'(e_own[d]));
        check($sformatf("m%0d.busy", d), 32'(a_busy), 32'(e_busy[d]));
        check($sformatf("m%0d.data", d), 32'(a_fd), 32'(ed));
      end
      model_update(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic         fl;
    logic [N-1:0] rdy;
    logic         wr;
    int           own;
    logic         busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst_n = 1'b0;
    valid = '0;
    full  = 1'b0;
    data  = {8'h43, 8'h32, 8'h21, 8'h10};
    #1;

    // Reset state, then the table: an early release bubble, a stall, wrap, and a late higher-priority arrival.
    do_reset();
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'b1001, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
    tbl[2]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 0, 1'b1};
    tbl[3]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
    tbl[4]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 3, 1'b1};
    tbl[5]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b1};
    tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 3, 1'b1};
    tbl[7]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 3, 1'b1};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0};
    tbl[11] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].vld;
      full  = tbl[i].fl;
      step();
      check($sformatf("tbl%0d.ready", i), 32'(s_rdy0), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d.wr", i), 32'(s_wr0), 32'(tbl[i].wr));
      check($sformatf("tbl%0d.owner", i), 32'(s_own0), 32'(tbl[i].own));
      check($sformatf("tbl%0d.busy", i), 32'(s_busy0), 32'(tbl[i].busy));
    end

    // All requesters valid: bursts of four in order, with a write on every cycle.
    do_reset();
    valid = 4'b1111; full = 1'b0;
    for (int c = 0; c < 17; c++) begin
      step();
      check("t1.wr", 32'(s_wr0), 32'd1);
      check("t1.order", 32'(s_own0), 32'((c / 4) % 4));
    end

    // Requester 2 alone: back-to-back bursts with no bubble.
    do_reset();
    valid = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      step();
      check("t2.wr", 32'(s_wr0), 32'd1);
      check("t2.owner", 32'(s_own0), 32'd2);
      check("t2.busy", 32'(s_busy0), 32'((c % 4) != 0));
    end

    // Owner 1 stalls at count 2 for five cycles, then takes exactly two more beats before rotating to 2.
    do_reset();
    valid = 4'b0110;
    step(); step();
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t3.stall_ready", 32'(s_rdy0), 32'd0);
      check("t3.stall_wr", 32'(s_wr0), 32'd0);
      check("t3.stall_owner", 32'(s_own0), 32'd1);
      check("t3.stall_busy", 32'(s_busy0), 32'd1);
    end
    full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("t3.tail_wr", 32'(s_wr0), 32'd1);
      check("t3.tail_owner", 32'(s_own0), 32'd1);
    end
    step();
    check("t3.rotate_owner", 32'(s_own0), 32'd2);
    check("t3.rotate_busy", 32'(s_busy0), 32'd0);

    // Reset in the middle of owner 3's burst: the burst is dropped and requester 0 wins first.
    do_reset();
    valid = 4'b1000;
    step(); step(); step();
    rst_n = 1'b0; valid = 4'b1111;
    step();
    check("t5.rst_ready", 32'(s_rdy0), 32'd0);
    check("t5.rst_wr", 32'(s_wr0), 32'd0);
    rst_n = 1'b1;
    step();
    check("t5.busy", 32'(s_busy0), 32'd0);
    check("t5.owner", 32'(s_own0), 32'd0);
    check("t5.ready", 32'(s_rdy0), 32'b0001);

    // Single-beat bursts: requesters 0 and 3 alternate on every cycle.
    do_reset();
    valid = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      step();
      check("t6.wr", 32'(s_wr1), 32'd1);
      check("t6.owner", 32'(s_own1), 32'((c % 2 == 0) ? 0 : 3));
      check("t6.busy", 32'(s_busy1), 32'd0);
    end

    // Random traffic with occasional resets. Data is held while a beat is pending on either instance.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(valid[k] && !(s_rdy0[k] && s_rdy1[k]))) data[k*W +: W] = W'($urandom);
        valid[k] = ($urandom_range(0, 99) < 70);
      end
      full  = ($urandom_range(0, 99) < 25);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
